rx_event_watchdog: RTL and testbench

Parametrised receiver watchdog. It monitors NUM_EVENTS abnormal-signal event lines coming from the upstream detectors (DC bias, equalizer collapse, phase offset, bad SIGNAL length, and so on).
- Counts rising edges per event in saturating counters that software can clear.
- Generates a receiver reset of programmable width, followed by a programmable hold-off window.
- Records which events caused the last reset.
- Sits between the rx pipeline monitors and the receiver reset tree; software reads it over AXI-lite.

---
 rtl/rx_event_watchdog_pkg.sv | 13 +
 rtl/rx_event_watchdog_sat_edge_counter.sv | 30 +++
 rtl/rx_event_watchdog.sv | 155 +++++++++++++++
 tb/tb_rx_event_watchdog.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_event_watchdog_pkg.sv
// Shared definitions for the receiver event watchdog: FSM state encodings
// and the width of the software-programmed reset pulse length.
package rx_event_watchdog_pkg;

  typedef enum logic [1:0] {
    S_WD_IDLE    = 2'd0,
    S_WD_RST     = 2'd1,
    S_WD_HOLDOFF = 2'd2
  } wd_state_t;

  localparam int PULSE_LEN_W = 8;

endpackage

// File: rtl/rx_event_watchdog_sat_edge_counter.sv
// Per-event saturating rising-edge counter. A clear in the same cycle as an
// increment wins, so that edge is dropped.
module sat_edge_counter #(
  parameter int COUNTER_WIDTH = 22
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rise,
  input  logic                     clr,
  output logic [COUNTER_WIDTH-1:0] count
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    sat_inc = (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  // Clear has priority over counting; counting sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (rise) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/rx_event_watchdog.sv
// Receiver watchdog: counts rising edges on the monitored event lines and
// issues a receiver reset pulse of programmable width followed by a
// hold-off window in which further triggers are ignored (but still counted).
module rx_event_watchdog #(
  parameter int NUM_EVENTS    = 8,
  parameter int SEL_WIDTH     = 4,
  parameter int COUNTER_WIDTH = 22,
  parameter int TIMER_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic                     power_trigger,
  input  logic [NUM_EVENTS-1:0]    events_in,
  input  logic [NUM_EVENTS-1:0]    event_mask,
  input  logic [7:0]               rst_pulse_len,
  input  logic [TIMER_WIDTH-1:0]   holdoff_len,
  input  logic [SEL_WIDTH-1:0]     event_selector,
  input  logic                     clr_valid,
  input  logic                     clr_all,
  output logic [COUNTER_WIDTH-1:0] event_counter,
  output logic [COUNTER_WIDTH-1:0] rst_count,
  output logic [NUM_EVENTS-1:0]    rst_cause,
  output logic                     busy,
  output logic                     receiver_rst
);

  import rx_event_watchdog_pkg::*;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    sat_inc = (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  wd_state_t                state;
  logic [TIMER_WIDTH-1:0]   timer;
  logic [NUM_EVENTS-1:0]    events_d;
  logic [NUM_EVENTS-1:0]    rise;
  logic [NUM_EVENTS-1:0]    masked_rise;
  logic [NUM_EVENTS-1:0]    cnt_clr;
  logic [COUNTER_WIDTH-1:0] cnt [NUM_EVENTS];
  logic                     trigger;
  logic [PULSE_LEN_W-1:0]   pulse_m1;

  assign rise        = events_in & ~events_d;
  assign masked_rise = rise & event_mask;
  assign trigger     = enable & power_trigger & (|masked_rise);
  // A zero pulse length behaves as a single-cycle pulse.
  assign pulse_m1    = (rst_pulse_len == '0) ? '0 : rst_pulse_len - 1'b1;

  // Delayed copy of the event lines for edge detection; clears never touch it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      events_d <= '0;
    end else begin
      events_d <= events_in;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_EVENTS; g++) begin : g_cnt
      // Out-of-range selectors never match any index, so they clear nothing.
      assign cnt_clr[g] = clr_valid & (clr_all | (event_selector == SEL_WIDTH'(g)));

      sat_edge_counter #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
      ) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .rise (rise[g]),
        .clr  (cnt_clr[g]),
        .count(cnt[g])
      );
    end
  endgenerate

  // Read-back mux of the selected counter; unmatched selectors read zero.
  always_comb begin
    event_counter = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (event_selector == SEL_WIDTH'(i)) begin
        event_counter = cnt[i];
      end
    end
  end

  // Reset-pulse counter; a global clear in the same cycle as a new pulse wins.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rst_count <= '0;
    end else if (clr_valid && clr_all) begin
      rst_count <= '0;
    end else if (state == S_WD_IDLE && trigger) begin
      rst_count <= sat_inc(rst_count);
    end
  end

  // Watchdog FSM with registered receiver_rst/busy; timer holds remaining cycles minus one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_WD_IDLE;
      timer        <= '0;
      rst_cause    <= '0;
      receiver_rst <= 1'b0;
      busy         <= 1'b0;
    end else if (!enable) begin
      state        <= S_WD_IDLE;
      receiver_rst <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_WD_IDLE: begin
          if (trigger) begin
            state        <= S_WD_RST;
            timer        <= TIMER_WIDTH'(pulse_m1);
            rst_cause    <= masked_rise;
            receiver_rst <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_WD_RST: begin
          if (timer == '0) begin
            receiver_rst <= 1'b0;
            if (holdoff_len != '0) begin
              state <= S_WD_HOLDOFF;
              timer <= holdoff_len - 1'b1;
              busy  <= 1'b1;
            end else begin
              state <= S_WD_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_WD_HOLDOFF: begin
          if (timer == '0) begin
            state <= S_WD_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state        <= S_WD_IDLE;
          receiver_rst <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_event_watchdog.sv
// Directed bench for rx_event_watchdog with NUM_EVENTS=8, COUNTER_WIDTH=4.
module tb_rx_event_watchdog;

  localparam int NE = 8;
  localparam int SW = 4;
  localparam int CW = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic          power_trigger;
  logic [NE-1:0] events_in;
  logic [NE-1:0] event_mask;
  logic [7:0]    rst_pulse_len;
  logic [TW-1:0] holdoff_len;
  logic [SW-1:0] event_selector;
  logic          clr_valid;
  logic          clr_all;
  logic [CW-1:0] event_counter;
  logic [CW-1:0] rst_count;
  logic [NE-1:0] rst_cause;
  logic          busy;
  logic          receiver_rst;

  int checks   = 0;
  int failures = 0;

  rx_event_watchdog #(
    .NUM_EVENTS   (NE),
    .SEL_WIDTH    (SW),
    .COUNTER_WIDTH(CW),
    .TIMER_WIDTH  (TW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .power_trigger (power_trigger),
    .events_in     (events_in),
    .event_mask    (event_mask),
    .rst_pulse_len (rst_pulse_len),
    .holdoff_len   (holdoff_len),
    .event_selector(event_selector),
    .clr_valid     (clr_valid),
    .clr_all       (clr_all),
    .event_counter (event_counter),
    .rst_count     (rst_count),
    .rst_cause     (rst_cause),
    .busy          (busy),
    .receiver_rst  (receiver_rst)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; power_trigger = 1'b0; events_in = '0;
    event_mask = '0; rst_pulse_len = '0; holdoff_len = '0;
    event_selector = '0; clr_valid = 1'b0; clr_all = 1'b0;
    step(); step();
    checks++; if (receiver_rst !== 1'b0) begin failures++; $display("FAIL reset_rx_rst got=%0h exp=0", receiver_rst); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (rst_count !== 4'd0) begin failures++; $display("FAIL reset_rst_count got=%0h exp=0", rst_count); end
    checks++; if (rst_cause !== 8'h00) begin failures++; $display("FAIL reset_rst_cause got=%0h exp=0", rst_cause); end
    checks++; if (event_counter !== 4'd0) begin failures++; $display("FAIL reset_counter got=%0h exp=0", event_counter); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_count_saturation();
    enable = 1'b0; power_trigger = 1'b1; event_mask = 8'hFF; event_selector = 4'd3;
    for (int i = 0; i < 20; i++) begin
      events_in[3] = 1'b1; step();
      events_in[3] = 1'b0; step();
      checks++; if (receiver_rst !== 1'b0) begin failures++; $display("FAIL sat_no_rst[%0d] got=%0h exp=0", i, receiver_rst); end
    end
    checks++; if (event_counter !== 4'd15) begin failures++; $display("FAIL sat_counter3 got=%0d exp=15", event_counter); end
    checks++; if (rst_count !== 4'd0) begin failures++; $display("FAIL sat_rst_count got=%0d exp=0", rst_count); end
    clr_valid = 1'b1; clr_all = 1'b1; step();
    clr_valid = 1'b0; clr_all = 1'b0;
    checks++; if (event_counter !== 4'd0) begin failures++; $display("FAIL sat_clear_all got=%0d exp=0", event_counter); end
  endtask

  task automatic test_pulse_holdoff();
    logic exp_rst;
    logic exp_busy;
    enable = 1'b1; power_trigger = 1'b1; event_mask = 8'h01;
    rst_pulse_len = 8'd3; holdoff_len = 16'd5; event_selector = 4'd0;
    events_in[0] = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) begin
      exp_rst  = (k <= 3);
      exp_busy = (k <= 8);
      checks++; if (receiver_rst !== exp_rst) begin failures++; $display("FAIL pulse_rx_rst cyc=%0d got=%0h exp=%0h", k, receiver_rst, exp_rst); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL pulse_busy cyc=%0d got=%0h exp=%0h", k, busy, exp_busy); end
      if (k == 1) events_in[0] = 1'b0;
      if (k == 4) events_in[0] = 1'b1;
      step();
    end
    checks++; if (event_counter !== 4'd2) begin failures++; $display("FAIL pulse_counter0 got=%0d exp=2", event_counter); end
    checks++; if (rst_count !== 4'd1) begin failures++; $display("FAIL pulse_rst_count got=%0d exp=1", rst_count); end
    checks++; if (rst_cause !== 8'h01) begin failures++; $display("FAIL pulse_rst_cause got=%0h exp=01", rst_cause); end
    events_in = '0;
    step();
  endtask

  task automatic test_cause_mask();
    event_mask = 8'h06;
    events_in = 8'h26;
    step();
    checks++; if (receiver_rst !== 1'b1) begin failures++; $display("FAIL cause_rx_rst got=%0h exp=1", receiver_rst); end
    checks++; if (rst_cause !== 8'h06) begin failures++; $display("FAIL cause_rst_cause got=%0h exp=06", rst_cause); end
    checks++; if (rst_count !== 4'd2) begin failures++; $display("FAIL cause_rst_count got=%0d exp=2", rst_count); end
    event_selector = 4'd1; #1;
    checks++; if (event_counter !== 4'd1) begin failures++; $display("FAIL cause_counter1 got=%0d exp=1", event_counter); end
    event_selector = 4'd2; #1;
    checks++; if (event_counter !== 4'd1) begin failures++; $display("FAIL cause_counter2 got=%0d exp=1", event_counter); end
    event_selector = 4'd5; #1;
    checks++; if (event_counter !== 4'd1) begin failures++; $display("FAIL cause_counter5 got=%0d exp=1", event_counter); end
    events_in = '0;
    for (int i = 0; i < 10; i++) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cause_idle_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_clear_priority();
    enable = 1'b0;
    events_in[2] = 1'b1; clr_valid = 1'b1; clr_all = 1'b0; event_selector = 4'd2;
    step();
    clr_valid = 1'b0;
    checks++; if (event_counter !== 4'd0) begin failures++; $display("FAIL clr_sel_counter2 got=%0d exp=0", event_counter); end
    event_selector = 4'd1; #1;
    checks++; if (event_counter !== 4'd1) begin failures++; $display("FAIL clr_sel_counter1 got=%0d exp=1", event_counter); end
    event_selector = 4'd0; #1;
    checks++; if (event_counter !== 4'd2) begin failures++; $display("FAIL clr_sel_counter0 got=%0d exp=2", event_counter); end
    event_selector = 4'd9; clr_valid = 1'b1; clr_all = 1'b0;
    step();
    clr_valid = 1'b0;
    checks++; if (event_counter !== 4'd0) begin failures++; $display("FAIL clr_oor_read got=%0d exp=0", event_counter); end
    event_selector = 4'd0; #1;
    checks++; if (event_counter !== 4'd2) begin failures++; $display("FAIL clr_oor_counter0 got=%0d exp=2", event_counter); end
    event_selector = 4'd5; #1;
    checks++; if (event_counter !== 4'd1) begin failures++; $display("FAIL clr_oor_counter5 got=%0d exp=1", event_counter); end
    clr_valid = 1'b1; clr_all = 1'b1;
    step();
    clr_valid = 1'b0; clr_all = 1'b0;
    checks++; if (event_counter !== 4'd0) begin failures++; $display("FAIL clr_all_counter5 got=%0d exp=0", event_counter); end
    event_selector = 4'd0; #1;
    checks++; if (event_counter !== 4'd0) begin failures++; $display("FAIL clr_all_counter0 got=%0d exp=0", event_counter); end
    checks++; if (rst_count !== 4'd0) begin failures++; $display("FAIL clr_all_rst_count got=%0d exp=0", rst_count); end
    events_in = '0;
    step();
  endtask

  task automatic test_abort_zero_len();
    enable = 1'b1; power_trigger = 1'b1; event_mask = 8'hFF;
    rst_pulse_len = 8'd0; holdoff_len = 16'd0;
    events_in[4] = 1'b1;
    step();
    checks++; if (receiver_rst !== 1'b1) begin failures++; $display("FAIL zero_pulse_on got=%0h exp=1", receiver_rst); end
    step();
    checks++; if (receiver_rst !== 1'b0) begin failures++; $display("FAIL zero_pulse_off got=%0h exp=0", receiver_rst); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_off got=%0h exp=0", busy); end
    checks++; if (rst_count !== 4'd1) begin failures++; $display("FAIL zero_rst_count got=%0d exp=1", rst_count); end
    events_in = '0;
    step();
    rst_pulse_len = 8'd10;
    events_in[4] = 1'b1;
    step();
    step(); step(); step();
    checks++; if (receiver_rst !== 1'b1) begin failures++; $display("FAIL abort_4th_cycle got=%0h exp=1", receiver_rst); end
    enable = 1'b0;
    step();
    checks++; if (receiver_rst !== 1'b0) begin failures++; $display("FAIL abort_rx_rst got=%0h exp=0", receiver_rst); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0h exp=0", busy); end
    step();
    checks++; if (receiver_rst !== 1'b0) begin failures++; $display("FAIL abort_stays_low got=%0h exp=0", receiver_rst); end
    checks++; if (rst_count !== 4'd2) begin failures++; $display("FAIL abort_rst_count got=%0d exp=2", rst_count); end
    checks++; if (rst_cause !== 8'h10) begin failures++; $display("FAIL abort_rst_cause got=%0h exp=10", rst_cause); end
    enable = 1'b1; events_in = '0;
    step();
  endtask

  task automatic test_reset_mid_operation();
    event_mask = 8'h01; rst_pulse_len = 8'd2; holdoff_len = 16'd6; event_selector = 4'd0;
    events_in[0] = 1'b1;
    step(); step(); step();
    checks++; if (busy !== 1'b1 || receiver_rst !== 1'b0) begin failures++; $display("FAIL mid_holdoff busy=%0h rx_rst=%0h exp busy=1 rx_rst=0", busy, receiver_rst); end
    rstn = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0h exp=0", busy); end
    checks++; if (receiver_rst !== 1'b0) begin failures++; $display("FAIL mid_rst_rx_rst got=%0h exp=0", receiver_rst); end
    checks++; if (rst_count !== 4'd0) begin failures++; $display("FAIL mid_rst_rst_count got=%0d exp=0", rst_count); end
    checks++; if (rst_cause !== 8'h00) begin failures++; $display("FAIL mid_rst_rst_cause got=%0h exp=0", rst_cause); end
    checks++; if (event_counter !== 4'd0) begin failures++; $display("FAIL mid_rst_counter0 got=%0d exp=0", event_counter); end
    rstn = 1'b1;
    step();
    checks++; if (event_counter !== 4'd1) begin failures++; $display("FAIL held_line_count got=%0d exp=1", event_counter); end
    step(); step(); step();
    checks++; if (event_counter !== 4'd1) begin failures++; $display("FAIL held_line_once got=%0d exp=1", event_counter); end
    events_in = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_count_saturation();
    test_pulse_holdoff();
    test_cause_mask();
    test_clear_priority();
    test_abort_zero_len();
    test_reset_mid_operation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
